// File: rtl/inst_loader.sv
// Boot loader: assembles a little-endian word-count header and instruction words from the UART
// byte stream and writes them to instruction RAM. Define INST_LOADER_CHECKSUM_EN for a trailing sum check.
module inst_loader #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_enable,
  output logic                  ram_write_enable,
  output logic [31:0]           ram_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   words_loaded
);

`ifdef INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StHdr, StData, StCsum, StDone, StErr} state_e;
  localparam state_e StLoaded = StCsum;
`else
  typedef enum logic [2:0] {StIdle, StHdr, StData, StDone, StErr} state_e;
  localparam state_e StLoaded = StDone;
`endif

  localparam logic [32:0]           Depth    = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

  state_e                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]           shift_q, shift_d;
  logic [31:0]           count_q, count_d;
  logic [ADDR_WIDTH:0]   wl_q, wl_d, wl_inc;
  logic                  ram_en_q, ram_en_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]           ram_wdata_q, ram_wdata_d;
  logic [31:0]           word;
  logic                  in_load;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0]           csum_q, csum_d;
`endif

  assign in_load = (state_q == StHdr) || (state_q == StData)
`ifdef INST_LOADER_CHECKSUM_EN
                   || (state_q == StCsum)
`endif
                   ;
  assign wl_inc = wl_q + (ADDR_WIDTH+1)'(1);

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    count_d     = count_q;
    wl_d        = wl_q;
    ram_en_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifdef INST_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    // Word as it stands once the current byte lands in its lane.
    word = shift_q;
    word[8*byte_idx_q +: 8] = rx_data;

    if (start) begin
      // start wins over a coincident rx_valid; that byte is dropped.
      state_d    = StHdr;
      byte_idx_d = 2'd0;
      wl_d       = '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_d     = '0;
`endif
    end else if (rx_valid && in_load) begin
      shift_d    = word;
      byte_idx_d = byte_idx_q + 2'd1;
      if (byte_idx_q == 2'd3) begin
        case (state_q)
          StHdr: begin
            count_d = word;
            if ({1'b0, word} > Depth) begin
              state_d = StErr;
            end else if (word == '0) begin
              state_d = StLoaded;
            end else begin
              state_d = StData;
            end
          end
          StData: begin
            ram_en_d    = 1'b1;
            ram_addr_d  = BaseAddr + wl_q[ADDR_WIDTH-1:0];
            ram_wdata_d = word;
            wl_d        = wl_inc;
`ifdef INST_LOADER_CHECKSUM_EN
            csum_d      = csum_q + word;
`endif
            if (32'(wl_inc) == count_q) begin
              state_d = StLoaded;
            end
          end
`ifdef INST_LOADER_CHECKSUM_EN
          StCsum: state_d = (word == csum_q) ? StDone : StErr;
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      byte_idx_q  <= 2'd0;
      shift_q     <= '0;
      count_q     <= '0;
      wl_q        <= '0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      count_q     <= count_d;
      wl_q        <= wl_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
`ifdef INST_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign ram_addr         = ram_addr_q;
  assign ram_enable       = ram_en_q;
  assign ram_write_enable = ram_en_q;
  assign ram_write_data   = ram_wdata_q;
  assign busy             = in_load;
  assign done             = (state_q == StDone);
  assign err              = (state_q == StErr);
  assign words_loaded     = wl_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: expected RAM writes are queued as bytes are driven and
// popped by a write monitor sampling on the falling edge.
module tb_inst_loader;
  localparam int unsigned AW   = 4;
  localparam int unsigned BASE = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic [AW-1:0] ram_addr;
  logic          ram_enable;
  logic          ram_write_enable;
  logic [31:0]   ram_write_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  int total  = 0;
  int passes = 0;
  int writes = 0;
  int widx   = 0;
  int w0     = 0;
  logic [31:0]   sum = 32'd0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] e;
  logic          prev_en = 1'b0;

  inst_loader #(
    .ADDR_WIDTH(AW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .ram_addr        (ram_addr),
    .ram_enable      (ram_enable),
    .ram_write_enable(ram_write_enable),
    .ram_write_data  (ram_write_data),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .words_loaded    (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (ram_enable) begin
      writes++;
      check("pulse_width", 64'(prev_en), 64'(0));
      check("we_eq_en", 64'(ram_write_enable), 64'(1));
      if (exp_q.size() == 0) begin
        check("unexpected_write_qsize", 64'(exp_q.size()), 64'(1));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(ram_addr), 64'(e[AW+31:32]));
        check("wr_data", 64'(ram_write_data), 64'(e[31:0]));
      end
    end
    prev_en = ram_enable;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic begin_load(input logic [31:0] n);
    pulse_start();
    widx = 0;
    sum  = 32'd0;
    send_word(n);
  endtask

  task automatic load_word(input logic [31:0] w);
    logic [AW-1:0] a;
    a = AW'(BASE + widx);
    exp_q.push_back({a, w});
    widx++;
    sum = sum + w;
    send_word(w);
  endtask

  task automatic finish_load();
`ifdef INST_LOADER_CHECKSUM_EN
    send_word(sum);
`endif
  endtask

  initial begin
    // Reset and idle behaviour
    tick();
    tick();
    check("reset_outputs", 64'({ram_addr, ram_enable, ram_write_enable, ram_write_data,
                                busy, done, err, words_loaded}), 64'(0));
    rst = 1'b0;
    send_word(32'h0102_0304);
    tick();
    check("idle_ignores_rx_busy", 64'(busy), 64'(0));
    check("idle_ignores_rx_writes", 64'(writes), 64'(0));

    // Two-word load, back-to-back bytes
    begin_load(32'd2);
    check("hdr_busy", 64'(busy), 64'(1));
    load_word(32'h0000_0013);
    check("mid_done", 64'(done), 64'(0));
    load_word(32'hDEAD_BEEF);
`ifndef INST_LOADER_CHECKSUM_EN
    check("done_with_pulse", 64'(ram_enable), 64'(1));
`endif
    finish_load();
    check("two_done", 64'(done), 64'(1));
    check("two_busy", 64'(busy), 64'(0));
    check("two_words_loaded", 64'(words_loaded), 64'(2));

    // Zero length
    tick();
    w0 = writes;
    begin_load(32'd0);
    finish_load();
    check("zero_done", 64'(done), 64'(1));
    check("zero_words_loaded", 64'(words_loaded), 64'(0));
    tick();
    check("zero_no_write", 64'(writes), 64'(w0));

    // Full depth: exactly 2**AW words, addresses wrap past the top
    begin_load(32'd16);
    for (int k = 0; k < 16; k++) load_word(32'hA000_0000 + 32'(k));
    finish_load();
    check("full_done", 64'(done), 64'(1));
    check("full_err", 64'(err), 64'(0));
    check("full_words_loaded", 64'(words_loaded), 64'(16));

    // Overflow: N = 17 exceeds depth
    tick();
    w0 = writes;
    begin_load(32'd17);
    check("ovf_err", 64'(err), 64'(1));
    check("ovf_busy", 64'(busy), 64'(0));
    send_word(32'h1111_1111);
    tick();
    check("ovf_no_write", 64'(writes), 64'(w0));
    check("ovf_err_held", 64'(err), 64'(1));
    pulse_start();
    check("start_clears_err", 64'(err), 64'(0));
    check("start_sets_busy", 64'(busy), 64'(1));

    // Restart mid-word; the byte coincident with start is discarded
    send_word(32'd2);
    send(8'hAA);
    send(8'hBB);
    start    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h09;
    tick();
    start    = 1'b0;
    rx_valid = 1'b0;
    widx = 0;
    sum  = 32'd0;
    send_word(32'd1);
    load_word(32'h1234_5678);
    finish_load();
    check("restart_done", 64'(done), 64'(1));
    check("restart_words_loaded", 64'(words_loaded), 64'(1));

    // Reset mid-DATA after two words
    begin_load(32'd3);
    load_word(32'h0000_1111);
    load_word(32'h0000_2222);
    send(8'h33);
    send(8'h44);
    w0 = writes;
    rst = 1'b1;
    #1;
    check("midrst_outputs", 64'({ram_addr, ram_enable, ram_write_enable, ram_write_data,
                                 busy, done, err, words_loaded}), 64'(0));
    tick();
    rst = 1'b0;
    send_word(32'h5566_7788);
    tick();
    check("midrst_no_write", 64'(writes), 64'(w0));
    check("midrst_idle", 64'({busy, done, err}), 64'(0));

`ifdef INST_LOADER_CHECKSUM_EN
    // Checksum match then mismatch
    begin_load(32'd2);
    load_word(32'd1);
    load_word(32'd2);
    send_word(32'd3);
    check("csum_ok_done", 64'(done), 64'(1));
    begin_load(32'd2);
    load_word(32'd1);
    load_word(32'd2);
    send_word(32'd4);
    check("csum_bad_err", 64'(err), 64'(1));
    check("csum_bad_done", 64'(done), 64'(0));
    check("csum_bad_words", 64'(words_loaded), 64'(2));
`endif

    tick();
    tick();
    check("all_writes_seen", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
